// File: rtl/multi_pulse_gen_pkg.sv
// Shared types and constants for the multi-channel pulse generator.
package multi_pulse_gen_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic MODE_CONT  = 1'b0;
   localparam logic MODE_BURST = 1'b1;

   // Shortest period that still gives one low and one high slot.
   localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/pulse_chan.sv
// One output channel: shadowed width/phase, phase-offset compare and the
// registered pulse output.
module pulse_chan
   import multi_pulse_gen_pkg::*;
#(
   parameter int CW        = 16,
   parameter int DEF_WIDTH = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [CW-1:0] cfg_width,
   input  logic [CW-1:0] cfg_phase,
   input  logic [CW-1:0] cnt,
   input  logic [CW-1:0] period,
   input  logic          load,
   input  logic          run,
   output logic          pulse
);

   logic [CW-1:0] sh_width;
   logic [CW-1:0] sh_phase;
   logic [CW-1:0] width;
   logic [CW-1:0] phase;
   logic [CW:0]   off;

   // Position inside the pulse window; one extra bit so cnt + period never wraps.
   always_comb begin
      off = '0;
      if (cnt >= phase) begin
         off = {1'b0, cnt} - {1'b0, phase};
      end else begin
         off = {1'b0, cnt} + {1'b0, period} - {1'b0, phase};
      end
   end

   // Shadow writes any time; active copy only follows the shadow on a load strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_width <= CW'(DEF_WIDTH);
         sh_phase <= '0;
         width    <= CW'(DEF_WIDTH);
         phase    <= '0;
      end else begin
         if (we) begin
            sh_width <= cfg_width;
            sh_phase <= cfg_phase;
         end
         if (load) begin
            width <= sh_width;
            phase <= sh_phase;
         end
      end
   end

   // Registered compare; a phase beyond the period silences the channel.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pulse <= 1'b0;
      end else begin
         pulse <= run && (phase < period) && (off < {1'b0, width});
      end
   end

endmodule

// File: rtl/multi_pulse_gen.sv
// Multi-channel pulse generator: run/burst FSM, shared period counter,
// global shadow registers and one pulse_chan per output.
//
// state | meaning
// IDLE  | counter held at 0, actives track shadows, waiting for enable/start
// RUN   | counter cycling 0..period-1, channels driving pulses
module multi_pulse_gen
   import multi_pulse_gen_pkg::*;
#(
   parameter int  NCH        = 4,
   parameter int  CW         = 16,
   parameter int  DEF_PERIOD = 10,
   parameter int  DEF_WIDTH  = 2,
   localparam int IW         = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   input  logic           mode,
   input  logic           start,
   input  logic           glb_we,
   input  logic [CW-1:0]  cfg_period,
   input  logic [CW-1:0]  cfg_burst,
   input  logic           ch_we,
   input  logic [IW-1:0]  ch_idx,
   input  logic [CW-1:0]  cfg_width,
   input  logic [CW-1:0]  cfg_phase,
   output logic [NCH-1:0] pulse,
   output logic           busy,
   output logic           done,
   output logic [CW-1:0]  cnt
);

   localparam logic [CW-1:0] ONE = CW'(1);

   state_t        state, state_nxt;
   logic          run_mode, run_mode_nxt;
   logic [CW-1:0] sh_period, act_period;
   logic [CW-1:0] sh_burst, act_burst;
   logic [CW-1:0] bcnt, bcnt_nxt;
   logic [CW-1:0] cnt_nxt;
   logic          done_nxt;
   logic          run;
   logic          wrap;
   logic          load;

   assign run  = (state == RUN);
   assign wrap = (cnt == act_period - ONE);
   assign load = !run || wrap;
   assign busy = run;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus next counter, burst counter and done strobe.
   always_comb begin
      state_nxt    = state;
      run_mode_nxt = run_mode;
      cnt_nxt      = cnt;
      bcnt_nxt     = bcnt;
      done_nxt     = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (mode == MODE_CONT) begin
               if (enable) begin
                  state_nxt    = RUN;
                  run_mode_nxt = MODE_CONT;
               end
            end else if (start) begin
               if (act_burst == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  state_nxt    = RUN;
                  run_mode_nxt = MODE_BURST;
                  bcnt_nxt     = act_burst;
               end
            end
         end
         RUN: begin
            if (wrap) begin
               cnt_nxt = '0;
               if (run_mode == MODE_CONT) begin
                  if (!enable) state_nxt = IDLE;
               end else begin
                  bcnt_nxt = bcnt - ONE;
                  if (bcnt == ONE) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end
               end
            end else begin
               cnt_nxt = cnt + ONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath registers that follow the FSM decisions.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_mode <= MODE_CONT;
         cnt      <= '0;
         bcnt     <= '0;
         done     <= 1'b0;
      end else begin
         run_mode <= run_mode_nxt;
         cnt      <= cnt_nxt;
         bcnt     <= bcnt_nxt;
         done     <= done_nxt;
      end
   end

   // Global shadows; the active period is clamped so the counter always toggles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_period  <= CW'(DEF_PERIOD);
         act_period <= CW'(DEF_PERIOD);
         sh_burst   <= ONE;
         act_burst  <= ONE;
      end else begin
         if (glb_we) begin
            sh_period <= cfg_period;
            sh_burst  <= cfg_burst;
         end
         if (load) begin
            act_period <= (sh_period < CW'(MIN_PERIOD)) ? CW'(MIN_PERIOD) : sh_period;
            act_burst  <= sh_burst;
         end
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      pulse_chan #(
         .CW        (CW),
         .DEF_WIDTH (DEF_WIDTH)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .we        (ch_we && (ch_idx == IW'(i))),
         .cfg_width (cfg_width),
         .cfg_phase (cfg_phase),
         .cnt       (cnt),
         .period    (act_period),
         .load      (load),
         .run       (run),
         .pulse     (pulse[i])
      );
   end

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Self-checking bench for multi_pulse_gen: directed scenarios plus random
// stimulus, all compared against a period/phase arithmetic model.
module tb_multi_pulse_gen;

   localparam int NCH = 4;
   localparam int CW  = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic           enable, mode, start, glb_we, ch_we;
   logic [1:0]     ch_idx;
   logic [CW-1:0]  cfg_period, cfg_burst, cfg_width, cfg_phase;
   logic [NCH-1:0] pulse;
   logic           busy, done;
   logic [CW-1:0]  cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   multi_pulse_gen #(.NCH(NCH), .CW(CW), .DEF_PERIOD(10), .DEF_WIDTH(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode), .start(start),
      .glb_we(glb_we), .cfg_period(cfg_period), .cfg_burst(cfg_burst),
      .ch_we(ch_we), .ch_idx(ch_idx), .cfg_width(cfg_width), .cfg_phase(cfg_phase),
      .pulse(pulse), .busy(busy), .done(done), .cnt(cnt)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit             m_run, m_mode, m_done;
   int             m_cnt, m_per, m_sper, m_burst, m_sburst, m_left;
   int             m_w[NCH], m_ph[NCH], m_sw[NCH], m_sph[NCH];
   logic [NCH-1:0] m_pulse;

   task automatic mdl_reset();
      m_run = 0; m_mode = 0; m_done = 0; m_cnt = 0; m_left = 0;
      m_per = 10; m_sper = 10; m_burst = 1; m_sburst = 1; m_pulse = '0;
      for (int i = 0; i < NCH; i++) begin
         m_w[i] = 2; m_sw[i] = 2; m_ph[i] = 0; m_sph[i] = 0;
      end
   endtask

   // Advance the model across one clock edge using the inputs currently driven.
   task automatic mdl_edge();
      logic [NCH-1:0] np;
      bit nrun, nmode, ndone, ld;
      int ncnt, nleft;
      for (int i = 0; i < NCH; i++)
         np[i] = m_run && (m_ph[i] < m_per) &&
                 (((m_cnt + m_per - m_ph[i]) % m_per) < m_w[i]);
      ld = !m_run || (m_cnt == m_per - 1);
      nrun = m_run; nmode = m_mode; ndone = 0; nleft = m_left; ncnt = m_cnt + 1;
      if (!m_run) begin
         ncnt = 0;
         if (!mode) begin
            if (enable) begin nrun = 1; nmode = 0; end
         end else if (start) begin
            if (m_burst == 0) ndone = 1;
            else begin nrun = 1; nmode = 1; nleft = m_burst; end
         end
      end else if (m_cnt == m_per - 1) begin
         ncnt = 0;
         if (!m_mode) nrun = enable;
         else begin
            nleft = nleft - 1;
            if (nleft == 0) begin nrun = 0; ndone = 1; end
         end
      end
      if (ld) begin
         m_per = (m_sper < 2) ? 2 : m_sper;
         m_burst = m_sburst;
         for (int i = 0; i < NCH; i++) begin m_w[i] = m_sw[i]; m_ph[i] = m_sph[i]; end
      end
      if (glb_we) begin m_sper = int'(cfg_period); m_sburst = int'(cfg_burst); end
      if (ch_we && int'(ch_idx) < NCH) begin
         m_sw[ch_idx] = int'(cfg_width); m_sph[ch_idx] = int'(cfg_phase);
      end
      m_run = nrun; m_mode = nmode; m_done = ndone; m_left = nleft;
      m_cnt = ncnt; m_pulse = np;
   endtask

   task automatic tick();
      mdl_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      enable = 0; mode = 0; start = 0; glb_we = 0; ch_we = 0; ch_idx = '0;
      cfg_period = '0; cfg_burst = '0; cfg_width = '0; cfg_phase = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1;
      mdl_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
   endtask

   task automatic write_ch(input int idx, input int w, input int ph);
      ch_we = 1; ch_idx = 2'(idx); cfg_width = CW'(w); cfg_phase = CW'(ph);
      tick();
      ch_we = 0;
   endtask

   task automatic write_glb(input int per, input int bur);
      glb_we = 1; cfg_period = CW'(per); cfg_burst = CW'(bur);
      tick();
      glb_we = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      clear_inputs();
      reset = 1;
      mdl_reset();
      #1;
      n_cmp++;
      if ({pulse, busy, done, cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got pulse=%b busy=%b done=%b cnt=%0d, want all 0",
                  pulse, busy, done, cnt);
      end
      @(posedge clk); #1;
      reset = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++;
         if ({pulse, busy, done, cnt} !== {m_pulse, m_run, m_done, CW'(m_cnt)}) begin
            n_fail++;
            $display("FAIL reset_idle k=%0d: got p=%b b=%b d=%b c=%0d want p=%b b=%b d=%b c=%0d",
                     k, pulse, busy, done, cnt, m_pulse, m_run, m_done, m_cnt);
         end
      end
   endtask

   task automatic test_defaults();
      bit exp0;
      do_reset();
      enable = 1;
      for (int k = 0; k < 25; k++) begin
         tick();
         n_cmp++;
         if ({pulse, busy, done, cnt} !== {m_pulse, m_run, m_done, CW'(m_cnt)}) begin
            n_fail++;
            $display("FAIL defaults_model k=%0d: got p=%b b=%b d=%b c=%0d want p=%b b=%b d=%b c=%0d",
                     k, pulse, busy, done, cnt, m_pulse, m_run, m_done, m_cnt);
         end
         if (k >= 1 && k <= 12) begin
            exp0 = (k == 1 || k == 2 || k == 11 || k == 12);
            n_cmp++;
            if (pulse !== {NCH{exp0}}) begin
               n_fail++;
               $display("FAIL defaults_shape after E%0d: got %b want %b", k, pulse, {NCH{exp0}});
            end
         end
      end
      enable = 0;
      for (int k = 0; k < 15; k++) tick();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL defaults_stop: busy got %b want 0", busy);
      end
   endtask

   task automatic test_phase();
      int c;
      do_reset();
      write_ch(1, 4, 3);
      write_ch(2, 4, 8);
      enable = 1;
      for (int k = 0; k < 25; k++) begin
         tick();
         n_cmp++;
         if ({pulse, busy, done, cnt} !== {m_pulse, m_run, m_done, CW'(m_cnt)}) begin
            n_fail++;
            $display("FAIL phase_model k=%0d: got p=%b b=%b d=%b c=%0d want p=%b b=%b d=%b c=%0d",
                     k, pulse, busy, done, cnt, m_pulse, m_run, m_done, m_cnt);
         end
         if (k >= 1) begin
            c = (k - 1) % 10;
            n_cmp++;
            if (pulse[1] !== (c >= 3 && c <= 6) || pulse[2] !== (c >= 8 || c <= 1)) begin
               n_fail++;
               $display("FAIL phase_window k=%0d: got ch1=%b ch2=%b want ch1=%b ch2=%b",
                        k, pulse[1], pulse[2], (c >= 3 && c <= 6), (c >= 8 || c <= 1));
            end
         end
      end
      enable = 0;
      for (int k = 0; k < 15; k++) tick();
   endtask

   task automatic test_burst();
      int npulse, ndone;
      do_reset();
      mode = 1;
      write_glb(5, 3);
      write_ch(0, 1, 0);
      tick();
      start = 1;
      tick();
      start = 0;
      npulse = 0; ndone = 0;
      for (int k = 1; k <= 30; k++) begin
         start = (k == 6);
         tick();
         npulse += int'(pulse[0]);
         ndone  += int'(done);
         n_cmp++;
         if ({pulse, busy, done, cnt} !== {m_pulse, m_run, m_done, CW'(m_cnt)}) begin
            n_fail++;
            $display("FAIL burst_model k=%0d: got p=%b b=%b d=%b c=%0d want p=%b b=%b d=%b c=%0d",
                     k, pulse, busy, done, cnt, m_pulse, m_run, m_done, m_cnt);
         end
         n_cmp++;
         if (done !== (k == 15)) begin
            n_fail++;
            $display("FAIL burst_done_time k=%0d: got %b want %b", k, done, (k == 15));
         end
      end
      start = 0;
      n_cmp++;
      if (npulse != 3 || ndone != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL burst_totals: got pulses=%0d dones=%0d busy=%b want 3 1 0",
                  npulse, ndone, busy);
      end
   endtask

   task automatic test_period_change();
      int guard;
      int expc;
      do_reset();
      enable = 1;
      guard = 0;
      tick();
      while (cnt !== CW'(2) && guard < 20) begin tick(); guard++; end
      n_cmp++;
      if (guard >= 20) begin
         n_fail++;
         $display("FAIL perchg_wait: cnt got %0d want 2 within 20 cycles", cnt);
      end
      write_glb(6, 1);
      for (int j = 0; j < 18; j++) begin
         tick();
         expc = (j < 6) ? 4 + j : (j - 6) % 6;
         n_cmp++;
         if (cnt !== CW'(expc)) begin
            n_fail++;
            $display("FAIL perchg_cnt j=%0d: got %0d want %0d", j, cnt, expc);
         end
         n_cmp++;
         if ({pulse, busy, done, cnt} !== {m_pulse, m_run, m_done, CW'(m_cnt)}) begin
            n_fail++;
            $display("FAIL perchg_model j=%0d: got p=%b b=%b d=%b c=%0d want p=%b b=%b d=%b c=%0d",
                     j, pulse, busy, done, cnt, m_pulse, m_run, m_done, m_cnt);
         end
      end
      enable = 0;
      for (int k = 0; k < 10; k++) tick();
   endtask

   task automatic test_edges();
      do_reset();
      write_ch(0, 0, 0);
      write_ch(1, 12, 0);
      write_ch(2, 2, 10);
      enable = 1;
      for (int k = 0; k < 25; k++) begin
         tick();
         n_cmp++;
         if ({pulse, busy, done, cnt} !== {m_pulse, m_run, m_done, CW'(m_cnt)}) begin
            n_fail++;
            $display("FAIL edges_model k=%0d: got p=%b b=%b d=%b c=%0d want p=%b b=%b d=%b c=%0d",
                     k, pulse, busy, done, cnt, m_pulse, m_run, m_done, m_cnt);
         end
         if (k >= 1) begin
            n_cmp++;
            if (pulse[2:0] !== 3'b010) begin
               n_fail++;
               $display("FAIL edges_const k=%0d: got ch2..0=%b want 010", k, pulse[2:0]);
            end
         end
      end
      enable = 0;
      for (int k = 0; k < 12; k++) tick();

      do_reset();
      write_glb(1, 1);
      tick();
      enable = 1;
      for (int k = 0; k < 12; k++) begin
         tick();
         n_cmp++;
         if (cnt !== CW'(k % 2) || (k >= 1 && pulse !== '1)) begin
            n_fail++;
            $display("FAIL edges_period1 k=%0d: got cnt=%0d pulse=%b want cnt=%0d pulse=1111",
                     k, cnt, pulse, k % 2);
         end
      end
      enable = 0;
      for (int k = 0; k < 4; k++) tick();

      do_reset();
      mode = 1;
      write_glb(10, 0);
      tick();
      start = 1;
      tick();
      start = 0;
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL edges_burst0_done: got done=%b busy=%b want 1 0", done, busy);
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         n_cmp++;
         if ({pulse, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL edges_burst0_quiet k=%0d: got p=%b b=%b d=%b want 0", k, pulse, busy, done);
         end
      end
   endtask

   task automatic test_reset_mid();
      int guard;
      do_reset();
      mode = 1;
      write_glb(10, 3);
      tick();
      start = 1;
      tick();
      start = 0;
      guard = 0;
      while (cnt !== CW'(5) && guard < 20) begin tick(); guard++; end
      n_cmp++;
      if (guard >= 20) begin
         n_fail++;
         $display("FAIL rstmid_wait: cnt got %0d want 5 within 20 cycles", cnt);
      end
      #2;
      reset = 1;
      mdl_reset();
      #1;
      n_cmp++;
      if ({pulse, busy, done, cnt} !== '0) begin
         n_fail++;
         $display("FAIL rstmid_abort: got pulse=%b busy=%b done=%b cnt=%0d want all 0",
                  pulse, busy, done, cnt);
      end
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      n_cmp++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_nodone: got done=%b want 0", done);
      end
      enable = 1;
      for (int k = 0; k < 22; k++) begin
         tick();
         n_cmp++;
         if ({pulse, busy, done, cnt} !== {m_pulse, m_run, m_done, CW'(m_cnt)}) begin
            n_fail++;
            $display("FAIL rstmid_model k=%0d: got p=%b b=%b d=%b c=%0d want p=%b b=%b d=%b c=%0d",
                     k, pulse, busy, done, cnt, m_pulse, m_run, m_done, m_cnt);
         end
      end
      n_cmp++;
      if (cnt !== CW'(1) || pulse !== '1) begin
         n_fail++;
         $display("FAIL rstmid_defaults: got cnt=%0d pulse=%b want cnt=1 pulse=1111", cnt, pulse);
      end
      enable = 0;
      for (int k = 0; k < 12; k++) tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 2000; k++) begin
         glb_we = ($urandom_range(0, 7) == 0);
         cfg_period = CW'($urandom_range(0, 12));
         cfg_burst  = CW'($urandom_range(0, 4));
         ch_we = ($urandom_range(0, 5) == 0);
         ch_idx = 2'($urandom_range(0, 3));
         cfg_width = CW'($urandom_range(0, 14));
         cfg_phase = CW'($urandom_range(0, 13));
         if ($urandom_range(0, 9) == 0) enable = ~enable;
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         start = ($urandom_range(0, 9) == 0);
         tick();
         n_cmp++;
         if ({pulse, busy, done, cnt} !== {m_pulse, m_run, m_done, CW'(m_cnt)}) begin
            n_fail++;
            $display("FAIL random_model k=%0d: got p=%b b=%b d=%b c=%0d want p=%b b=%b d=%b c=%0d",
                     k, pulse, busy, done, cnt, m_pulse, m_run, m_done, m_cnt);
         end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_phase();
      test_burst();
      test_period_change();
      test_edges();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_pulse_gen.md
Name: multi_pulse_gen

Overview:
- Multi-channel, runtime-programmable pulse generator: one shared period counter drives NCH channels, each with its own programmable width and phase offset.
- Supports two modes. Continuous mode runs while enabled. Burst mode emits burst_len periods after a start strobe, then signals done.
- Configuration writes are double-buffered (shadowed) so period, width and phase change only on a period boundary, with no glitches.
- Sits between the control register block and timing-output pins (strobes, ADC triggers, multi-phase drive).

Parameters:
- NCH, 4, number of output channels (1..16).
- CW, 16, counter/config field width in bits.
- DEF_PERIOD, 10, period loaded at reset (clock cycles).
- DEF_WIDTH, 2, width loaded into every channel at reset.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  continuous mode: run while high
- mode  in  1  0 = continuous, 1 = burst; sampled only in IDLE
- start  in  1  burst-mode start strobe; honoured only in IDLE
- glb_we  in  1  write cfg_period and cfg_burst to the shadow registers
- cfg_period  in  CW  period in cycles
- cfg_burst  in  CW  number of periods per burst
- ch_we  in  1  write per-channel shadow registers
- ch_idx  in  $clog2(NCH) (min 1)  channel select for ch_we
- cfg_width  in  CW  high time in cycles
- cfg_phase  in  CW  phase offset in cycles
- pulse  out  NCH  registered channel outputs
- busy  out  1  high while state is RUN
- done  out  1  one-cycle strobe at end of burst
- cnt  out  CW  current period counter value

Behaviour:
- Reset (asynchronous) clears the following:
  - state to IDLE; cnt, burst counter, pulse, busy and done to 0.
  - Shadow and active period to DEF_PERIOD; all widths to DEF_WIDTH; all phases to 0; burst to 1.
- Period clamp: any effective period below 2 is treated as 2.
- Shadow registers:
  - glb_we and ch_we write the shadows in any state; the last write before a boundary wins.
  - Active registers load from the shadows when in IDLE (every cycle) and on each wrap cycle (cnt == period-1) in RUN.
  - An out-of-range ch_idx (>= NCH) is ignored.
- State IDLE:
  - cnt = 0; pulse is driven 0 on the next edge.
  - Continuous mode: enable=1 moves to RUN.
  - Burst mode: start=1 moves to RUN with the burst counter loaded from the active burst value.
  - Burst mode with burst == 0: start produces done=1 on the next cycle and stays in IDLE; no pulses.
- State RUN:
  - cnt increments each cycle and wraps to 0 after period-1.
  - At each wrap, continuous mode checks enable; if enable=0, return to IDLE. Deasserting enable therefore completes the current period.
  - At each wrap in burst mode, the burst counter decrements; on the last period, go to IDLE and assert done for 1 cycle.
  - start and mode are ignored while in RUN.
- Channel compare (registered, 1-cycle latency):
  - off = cnt - phase if cnt >= phase, else cnt + period - phase.
  - On the next edge, pulse[i] <= (state == RUN) && (phase_i < period) && (off < width_i).
  - width >= period gives a constant high while running; width == 0 gives constant low; phase >= period forces the channel low.
- Timing: with enable first sampled high at edge E0, cnt = 0 after E0 and the first compare result appears after E1. The output trails cnt by exactly one cycle.
- busy mirrors state == RUN.
- Reset asserted mid-operation aborts immediately to reset values; no done strobe is produced.
- Arithmetic is unsigned CW-bit. off is computed at CW+1 bits so it does not overflow.

Decomposition:
- Package multi_pulse_gen_pkg contains:
  - state enum {IDLE, RUN};
  - mode constants MODE_CONT = 0, MODE_BURST = 1;
  - MIN_PERIOD = 2.
- Sub-module pulse_chan (one instance per channel) holds:
  - the width and phase shadow and active registers;
  - the phase-offset compare;
  - the output flop.
  Inputs are cnt, active period, the load strobe and run.
- Top level holds the FSM, the period and burst counters, and the global shadow registers.

Test Plan:
- Defaults, continuous mode, enable=1 at E0: pulse[0] high after E1 and E2, low for the next 8 cycles, high again after E11. All 4 channels are identical.
- Period 10; ch1 phase 3, width 4; ch2 phase 8, width 4: ch1 is high for cnt 3..6 (output one cycle later); ch2 is high for cnt 8, 9, 0, 1, wrapping across the boundary.
- Burst mode with burst=3, period=5, width=1, start pulsed: exactly 3 pulses on ch0; done high for 1 cycle on the cycle after the cnt == 4 of the 3rd period; busy low afterwards. A second start during RUN is ignored.
- Write period=6 at cnt=2 while running with period 10: the current period completes (cnt reaches 9), the next period has length 6, and there is no runt pulse.
- Edge cases:
  - width 0: pulse stays 0.
  - width 12 with period 10: stays 1.
  - phase 10 with period 10: stays 0.
  - cfg_period=1: behaves as period 2.
  - burst 0 with start: done after 1 cycle and no pulses.
- Assert reset while cnt=5 in burst mode: pulse, busy, done and cnt all 0 immediately, with no done strobe; period returns to 10 and width to 2.
